// File: rtl/pc_fetch.sv
// Program counter register and instruction-fetch sequencer.
// Holds pc/pc4, runs the instruction-memory request/ready handshake with a
// bounded wait, and hands each fetched word to decode with a valid/stall
// handshake. Every output is a register; imem_addr is the pc register itself.
module pc_fetch #(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter int          IMEM_TIMEOUT = 15
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] saida_pc,
    input  logic        stall,
    input  logic        imem_ready,
    input  logic [31:0] imem_data,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    output logic [31:0] pc,
    output logic [31:0] pc4,
    output logic [31:0] instrucao,
    output logic        instr_valid,
    output logic        erro_fetch
);

    // Timer counts the ready-low edges seen in FETCH; it never exceeds
    // IMEM_TIMEOUT-1 because that edge moves the FSM to ERROR.
    localparam int          TW          = $clog2(IMEM_TIMEOUT + 1);
    localparam logic [TW-1:0] TIMER_LAST = TW'(IMEM_TIMEOUT - 1);
    localparam logic [31:0] RESET_PC4   = RESET_PC + 32'd4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        VALID = 2'd2,
        ERROR = 2'd3
    } state_t;

    state_t        state_reg, state_next;
    logic [31:0]   pc_reg, pc_next;
    logic [31:0]   pc4_reg, pc4_next;
    logic [31:0]   instr_reg, instr_next;
    logic          valid_reg, valid_next;
    logic          req_reg, req_next;
    logic          err_reg, err_next;
    logic [TW-1:0] timer_reg, timer_next;

    // State and output registers; synchronous reset abandons any fetch in flight.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg <= IDLE;
            pc_reg    <= RESET_PC;
            pc4_reg   <= RESET_PC4;
            instr_reg <= 32'h0;
            valid_reg <= 1'b0;
            req_reg   <= 1'b0;
            err_reg   <= 1'b0;
            timer_reg <= '0;
        end else begin
            state_reg <= state_next;
            pc_reg    <= pc_next;
            pc4_reg   <= pc4_next;
            instr_reg <= instr_next;
            valid_reg <= valid_next;
            req_reg   <= req_next;
            err_reg   <= err_next;
            timer_reg <= timer_next;
        end
    end

    // Next-state and next-output logic; everything holds unless a case changes it.
    always_comb begin
        state_next = state_reg;
        pc_next    = pc_reg;
        pc4_next   = pc4_reg;
        instr_next = instr_reg;
        valid_next = valid_reg;
        req_next   = req_reg;
        err_next   = err_reg;
        timer_next = timer_reg;

        case (state_reg)
            IDLE: begin
                state_next = FETCH;
                req_next   = 1'b1;
            end

            FETCH: begin
                // stall is deliberately ignored here: decode has nothing yet.
                if (imem_ready) begin
                    instr_next = imem_data;
                    valid_next = 1'b1;
                    req_next   = 1'b0;
                    timer_next = '0;
                    state_next = VALID;
                end else if (timer_reg == TIMER_LAST) begin
                    req_next   = 1'b0;
                    err_next   = 1'b1;
                    state_next = ERROR;
                end else begin
                    timer_next = timer_reg + TW'(1);
                end
            end

            VALID: begin
                if (!stall) begin
                    // Instruction consumed: saida_pc is only trusted on this edge.
                    pc_next    = saida_pc;
                    pc4_next   = saida_pc + 32'd4;
                    valid_next = 1'b0;
                    if (saida_pc[1:0] == 2'b00) begin
                        req_next   = 1'b1;
                        state_next = FETCH;
                    end else begin
                        err_next   = 1'b1;
                        state_next = ERROR;
                    end
                end
            end

            ERROR: begin
                // Sticky until reset; pc keeps the offending/stalled address.
                req_next   = 1'b0;
                valid_next = 1'b0;
                err_next   = 1'b1;
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign imem_req    = req_reg;
    assign imem_addr   = pc_reg;
    assign pc          = pc_reg;
    assign pc4         = pc4_reg;
    assign instrucao   = instr_reg;
    assign instr_valid = valid_reg;
    assign erro_fetch  = err_reg;

endmodule

// File: tb/tb_pc_fetch.sv
// Self-checking bench for pc_fetch: transaction-level expectations (expected pc
// tracked per consumed instruction) with randomized wait/stall/branch stimulus.
module tb_pc_fetch;

    localparam int TIMEOUT = 15;

    logic        clock = 1'b0;

    // Instance A: default reset PC
    logic        rst_a = 1'b1;
    logic [31:0] saida_a = 32'h0;
    logic        stall_a = 1'b0;
    logic        ready_a = 1'b0;
    logic [31:0] data_a = 32'h0;
    logic        req_a, valid_a, err_a;
    logic [31:0] addr_a, pc_a, pc4_a, instr_a;

    // Instance B: reset PC at the top of the address space
    logic        rst_b = 1'b1;
    logic [31:0] saida_b = 32'h0;
    logic        stall_b = 1'b0;
    logic        ready_b = 1'b0;
    logic [31:0] data_b = 32'h0;
    logic        req_b, valid_b, err_b;
    logic [31:0] addr_b, pc_b, pc4_b, instr_b;

    int          vectors = 0;
    int          miscompares = 0;
    logic [31:0] exp_pc;

    pc_fetch #(.RESET_PC(32'h0000_0000), .IMEM_TIMEOUT(TIMEOUT)) dut_a (
        .clock(clock), .reset(rst_a), .saida_pc(saida_a), .stall(stall_a),
        .imem_ready(ready_a), .imem_data(data_a), .imem_req(req_a),
        .imem_addr(addr_a), .pc(pc_a), .pc4(pc4_a), .instrucao(instr_a),
        .instr_valid(valid_a), .erro_fetch(err_a)
    );

    pc_fetch #(.RESET_PC(32'hFFFF_FFFC), .IMEM_TIMEOUT(TIMEOUT)) dut_b (
        .clock(clock), .reset(rst_b), .saida_pc(saida_b), .stall(stall_b),
        .imem_ready(ready_b), .imem_data(data_b), .imem_req(req_b),
        .imem_addr(addr_b), .pc(pc_b), .pc4(pc4_b), .instrucao(instr_b),
        .instr_valid(valid_b), .erro_fetch(err_b)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Hold reset, check the reset values, release and check the first request.
    task automatic reset_a();
        rst_a = 1'b1; ready_a = 1'b0; stall_a = 1'b0;
        tick(); tick();
        chk("rst_pc", pc_a, 32'h0);
        chk("rst_pc4", pc4_a, 32'h4);
        chk("rst_req", {31'h0, req_a}, 32'h0);
        chk("rst_valid", {31'h0, valid_a}, 32'h0);
        chk("rst_instr", instr_a, 32'h0);
        chk("rst_err", {31'h0, err_a}, 32'h0);
        rst_a = 1'b0;
        tick();
        exp_pc = 32'h0;
        chk("first_req", {31'h0, req_a}, 32'h1);
        chk("first_addr", addr_a, exp_pc);
        $display("reset: pc=%h req=%b err=%b", pc_a, req_a, err_a);
    endtask

    // One instruction: wait, accept, stall, consume with next_pc.
    task automatic fetch_consume(input int waits, input logic [31:0] data,
                                 input int stalls, input logic [31:0] next_pc);
        for (int i = 0; i < waits; i++) begin
            ready_a = 1'b0; data_a = $urandom; stall_a = 1'($urandom);
            tick();
            chk("wait_req", {31'h0, req_a}, 32'h1);
            chk("wait_valid", {31'h0, valid_a}, 32'h0);
            chk("wait_addr", addr_a, exp_pc);
            chk("wait_pc", pc_a, exp_pc);
        end
        ready_a = 1'b1; data_a = data; stall_a = 1'($urandom);
        tick();
        chk("acc_valid", {31'h0, valid_a}, 32'h1);
        chk("acc_instr", instr_a, data);
        chk("acc_req", {31'h0, req_a}, 32'h0);
        chk("acc_pc", pc_a, exp_pc);
        chk("acc_pc4", pc4_a, exp_pc + 32'd4);
        for (int i = 0; i < stalls; i++) begin
            stall_a = 1'b1; saida_a = $urandom; ready_a = 1'($urandom); data_a = $urandom;
            tick();
            chk("stall_valid", {31'h0, valid_a}, 32'h1);
            chk("stall_instr", instr_a, data);
            chk("stall_pc", pc_a, exp_pc);
            chk("stall_req", {31'h0, req_a}, 32'h0);
        end
        stall_a = 1'b0; saida_a = next_pc; ready_a = 1'($urandom); data_a = $urandom;
        tick();
        exp_pc = next_pc;
        chk("cons_pc", pc_a, exp_pc);
        chk("cons_pc4", pc4_a, exp_pc + 32'd4);
        chk("cons_valid", {31'h0, valid_a}, 32'h0);
        if (next_pc[1:0] == 2'b00) begin
            chk("cons_req", {31'h0, req_a}, 32'h1);
            chk("cons_addr", addr_a, exp_pc);
            chk("cons_err", {31'h0, err_a}, 32'h0);
        end else begin
            chk("mis_err", {31'h0, err_a}, 32'h1);
            chk("mis_req", {31'h0, req_a}, 32'h0);
        end
        ready_a = 1'b0;
        $display("txn: waits=%0d stalls=%0d instr=%h next_pc=%h pc=%h err=%b",
                 waits, stalls, data, next_pc, pc_a, err_a);
    endtask

    initial begin
        logic [31:0] nxt;
        logic [31:0] wrap_pc4;

        // Instance A: reset, then T1 sequential fetches 0,4,8,12
        reset_a();
        for (int k = 0; k < 4; k++) begin
            chk("seq_pc", pc_a, 32'(k * 4));
            fetch_consume(0, $urandom, 0, exp_pc + 32'd4);
        end

        // T2 three stall cycles, then consume once
        fetch_consume(0, 32'hDEAD_BEEF, 3, exp_pc + 32'd4);
        // T3 branch to 0x40
        fetch_consume(1, $urandom, 0, 32'h0000_0040);
        chk("br_pc4", pc4_a, 32'h0000_0044);
        // Longest wait that still succeeds
        fetch_consume(TIMEOUT - 1, 32'h1234_5678, 1, exp_pc + 32'd4);

        // Randomized transactions
        for (int n = 0; n < 20; n++) begin
            if ($urandom_range(0, 1) == 0) nxt = exp_pc + 32'd4;
            else nxt = $urandom & 32'hFFFF_FFFC;
            fetch_consume(int'($urandom_range(0, 6)), $urandom,
                          int'($urandom_range(0, 3)), nxt);
        end

        // Reset mid-fetch abandons the request
        ready_a = 1'b0; rst_a = 1'b1;
        tick();
        chk("midrst_req", {31'h0, req_a}, 32'h0);
        chk("midrst_pc", pc_a, 32'h0);
        $display("mid-fetch reset: req=%b pc=%h", req_a, pc_a);
        reset_a();

        // T4 timeout after TIMEOUT ready-low edges
        for (int i = 0; i < TIMEOUT; i++) begin
            ready_a = 1'b0;
            tick();
            if (i < TIMEOUT - 1) begin
                chk("to_err_low", {31'h0, err_a}, 32'h0);
                chk("to_req_high", {31'h0, req_a}, 32'h1);
            end else begin
                chk("to_err", {31'h0, err_a}, 32'h1);
                chk("to_req", {31'h0, req_a}, 32'h0);
            end
        end
        for (int i = 0; i < 2; i++) begin
            ready_a = 1'b1; data_a = $urandom;
            tick();
            chk("to_sticky_err", {31'h0, err_a}, 32'h1);
            chk("to_sticky_valid", {31'h0, valid_a}, 32'h0);
            chk("to_sticky_req", {31'h0, req_a}, 32'h0);
            chk("to_sticky_pc", pc_a, 32'h0);
        end
        $display("timeout: err=%b req=%b", err_a, req_a);
        reset_a();

        // T5 misaligned next PC, error sticky until reset
        fetch_consume(1, $urandom, 0, 32'h0000_0042);
        for (int i = 0; i < 2; i++) begin
            ready_a = 1'b1; stall_a = 1'($urandom); saida_a = $urandom;
            tick();
            chk("mis_sticky_err", {31'h0, err_a}, 32'h1);
            chk("mis_sticky_pc", pc_a, 32'h0000_0042);
            chk("mis_sticky_valid", {31'h0, valid_a}, 32'h0);
        end
        reset_a();

        // T6 wrap-around on instance B
        wrap_pc4 = 32'hFFFF_FFFC + 32'd4;
        rst_b = 1'b1;
        tick();
        chk("b_rst_pc", pc_b, 32'hFFFF_FFFC);
        chk("b_rst_pc4", pc4_b, wrap_pc4);
        rst_b = 1'b0;
        tick();
        chk("b_req", {31'h0, req_b}, 32'h1);
        chk("b_addr", addr_b, 32'hFFFF_FFFC);
        ready_b = 1'b1; data_b = 32'hCAFE_F00D;
        tick();
        chk("b_valid", {31'h0, valid_b}, 32'h1);
        chk("b_instr", instr_b, 32'hCAFE_F00D);
        ready_b = 1'b0; stall_b = 1'b0; saida_b = pc4_b;
        tick();
        chk("b_wrap_pc", pc_b, wrap_pc4);
        chk("b_wrap_pc4", pc4_b, wrap_pc4 + 32'd4);
        chk("b_wrap_req", {31'h0, req_b}, 32'h1);
        $display("wrap: pc=%h pc4=%h", pc_b, pc4_b);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
